// File: rtl/line_draw_engine.sv
// line_draw_engine
//   Bresenham line rasteriser. Latches two endpoints and a colour when
//   `start` is seen in IDLE, then emits one pixel per clock on
//   vga_x/vga_y/vga_colour with vga_plot high, then holds `done` until
//   `start` falls.
//
// Ports:
//   CLOCK_50            system clock, rising edge
//   reset               synchronous, active-high
//   start               level request, sampled only in IDLE
//   x0, x1 [7:0]        endpoint X (unsigned)
//   y0, y1 [6:0]        endpoint Y (unsigned)
//   colour [2:0]        colour for every pixel of the line
//   vga_x [7:0]         current pixel X
//   vga_y [6:0]         current pixel Y
//   vga_colour [2:0]    latched colour
//   vga_plot            pixel write strobe
//   done                line complete, held until start falls
//
// Optional feature macro: LINE_CLIP_EN -- suppresses vga_plot for points
// outside SCREEN_W x SCREEN_H; stepping and timing are unchanged.

module line_draw_engine #(
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] x0,
  input  logic [7:0] x1,
  input  logic [6:0] y0,
  input  logic [6:0] y1,
  input  logic [2:0] colour,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       done
);

`ifdef LINE_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_DRAW, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [7:0]         x_q, x_d, x1_q, x1_d;
  logic [6:0]         y_q, y_d, y1_q, y1_d;
  logic [2:0]         colour_q, colour_d;
  logic               sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  logic [8:0]         dx_q, dx_d;
  logic signed [10:0] dy_q, dy_d;
  logic signed [10:0] err_q, err_d;

  logic [7:0]         abs_dx;
  logic [6:0]         abs_dy;
  logic signed [10:0] dx_ext, e2, err_step;
  logic               step_x, step_y, at_end, on_screen;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    colour_d = colour_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    err_d    = err_q;

    abs_dx   = (x1_q > x_q) ? (x1_q - x_q) : (x_q - x1_q);
    abs_dy   = (y1_q > y_q) ? (y1_q - y_q) : (y_q - y1_q);
    dx_ext   = $signed({2'b00, dx_q});
    e2       = err_q <<< 1;
    at_end   = (x_q == x1_q) && (y_q == y1_q);
    step_x   = (e2 >= dy_q);
    step_y   = (e2 <= dx_ext);
    // Both adjustments are taken from the old err in the same cycle.
    err_step = err_q + (step_x ? dy_q : '0) + (step_y ? dx_ext : '0);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d      = x0;
          y_d      = y0;
          x1_d     = x1;
          y1_d     = y1;
          colour_d = colour;
          state_d  = S_INIT;
        end
      end
      S_INIT: begin
        sx_neg_d = !(x_q < x1_q);
        sy_neg_d = !(y_q < y1_q);
        dx_d     = {1'b0, abs_dx};
        dy_d     = -$signed({4'b0000, abs_dy});
        err_d    = $signed({3'b000, abs_dx}) - $signed({4'b0000, abs_dy});
        state_d  = S_DRAW;
      end
      S_DRAW: begin
        if (at_end) begin
          state_d = S_DONE;
        end else begin
          err_d = err_step;
          if (step_x) x_d = sx_neg_q ? (x_q - 8'd1) : (x_q + 8'd1);
          if (step_y) y_d = sy_neg_q ? (y_q - 7'd1) : (y_q + 7'd1);
        end
      end
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      colour_q <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      colour_q <= colour_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    on_screen  = (32'(x_q) < SCREEN_W) && (32'(y_q) < SCREEN_H);
    vga_x      = x_q;
    vga_y      = y_q;
    vga_colour = colour_q;
    vga_plot   = (state_q == S_DRAW) && (!CLIP_EN || on_screen);
    done       = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_line_draw_engine.sv
module tb_line_draw_engine;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] x0 = '0, x1 = '0;
  logic [6:0] y0 = '0, y1 = '0;
  logic [2:0] colour = '0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot, done;

  line_draw_engine #(.SCREEN_W(160), .SCREEN_H(120)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1), .colour(colour),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .done(done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

`ifdef LINE_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  typedef struct {
    bit plot;
    bit dn;
    int x;
    int y;
    int col;
  } rec_t;

  rec_t exp_q[$];
  rec_t cr;
  int   mx[$];
  int   my[$];
  int   total = 0;
  int   bad = 0;
  bit   check_idle = 0;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Reference rasteriser: the textbook integer Bresenham rule on plain ints.
  task automatic build(input int ax0, input int ay0, input int ax1, input int ay1);
    int dx, dy, sx, sy, err, e2, cx, cy;
    mx.delete();
    my.delete();
    dx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
    dy = -((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1);
    sx = (ax0 < ax1) ? 1 : -1;
    sy = (ay0 < ay1) ? 1 : -1;
    err = dx + dy;
    cx = ax0;
    cy = ay0;
    forever begin
      mx.push_back(cx);
      my.push_back(cy);
      if (cx == ax1 && cy == ay1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; cx += sx; end
      if (e2 <= dx) begin err += dx; cy += sy; end
    end
  endtask

  function automatic bit plot_exp(input int px, input int py);
    return CLIP ? (px < 160 && py < 120) : 1'b1;
  endfunction

  // Compare process: one expected record per cycle while a line is in flight.
  always @(posedge CLOCK_50) begin
    #1;
    if (exp_q.size() > 0) begin
      cr = exp_q.pop_front();
      chk("plot", int'(vga_plot), int'(cr.plot));
      chk("done", int'(done), int'(cr.dn));
      chk("x", int'(vga_x), cr.x);
      chk("y", int'(vga_y), cr.y);
      chk("colour", int'(vga_colour), cr.col);
    end else if (check_idle) begin
      chk("idle_plot", int'(vga_plot), 0);
      chk("idle_done", int'(done), 0);
    end
  end

  task automatic push(input bit p, input bit d, input int px, input int py, input int pc);
    rec_t r;
    r.plot = p; r.dn = d; r.x = px; r.y = py; r.col = pc;
    exp_q.push_back(r);
  endtask

  task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                          input int acol, input int hold);
    int n;
    build(ax0, ay0, ax1, ay1);
    n = mx.size();
    @(negedge CLOCK_50);
    x0 = 8'(ax0); y0 = 7'(ay0); x1 = 8'(ax1); y1 = 7'(ay1);
    colour = 3'(acol);
    start = 1'b1;
    push(0, 0, ax0, ay0, acol);
    for (int i = 0; i < n; i++) push(plot_exp(mx[i], my[i]), 0, mx[i], my[i], acol);
    for (int i = 0; i < hold; i++) push(0, 1, ax1, ay1, acol);
    push(0, 0, ax1, ay1, acol);
    @(negedge CLOCK_50);
    // Inputs moving after the latch must not disturb the line.
    x0 = 8'($urandom); y0 = 7'($urandom); x1 = 8'($urandom); y1 = 7'($urandom);
    colour = 3'($urandom);
    repeat (n + hold) @(negedge CLOCK_50);
    start = 1'b0;
    @(negedge CLOCK_50);
  endtask

  initial begin
    int steps_x, bad_unit, diag_bad, ax0, ay0, ax1, ay1, adx, ady, mxd;

    repeat (2) @(negedge CLOCK_50);
    chk("rst_x", int'(vga_x), 0);
    chk("rst_y", int'(vga_y), 0);
    chk("rst_colour", int'(vga_colour), 0);
    chk("rst_plot", int'(vga_plot), 0);
    chk("rst_done", int'(done), 0);
    reset = 1'b0;
    check_idle = 1;
    @(negedge CLOCK_50);

    // Model pins from hand-worked cases.
    build(0, 0, 159, 0);
    chk("pin_h_len", mx.size(), 160);
    chk("pin_h_last_x", mx[159], 159);
    build(5, 5, 5, 5);
    chk("pin_pt_len", mx.size(), 1);
    build(10, 100, 0, 0);
    chk("pin_steep_len", mx.size(), 101);
    chk("pin_steep_first_y", my[0], 100);
    steps_x = 0;
    bad_unit = 0;
    for (int i = 1; i < mx.size(); i++) begin
      if (mx[i] == mx[i-1] - 1) steps_x++;
      if (my[i] != my[i-1] - 1) bad_unit++;
    end
    chk("pin_steep_xsteps", steps_x, 10);
    chk("pin_steep_ystep", bad_unit, 0);
    build(0, 0, 119, 119);
    chk("pin_diag_len", mx.size(), 120);
    diag_bad = 0;
    for (int i = 0; i < mx.size(); i++) if (mx[i] != my[i]) diag_bad++;
    chk("pin_diag_xeqy", diag_bad, 0);

    // Directed lines.
    run_line(0, 0, 159, 0, 4, 1);
    run_line(5, 5, 5, 5, 2, 2);
    run_line(10, 100, 0, 0, 7, 1);
    run_line(0, 0, 119, 119, 1, 1);
    run_line(150, 0, 170, 0, 5, 12);

    // Reset at pixel 20 of the horizontal line.
    build(0, 0, 159, 0);
    @(negedge CLOCK_50);
    x0 = 8'd0; y0 = 7'd0; x1 = 8'd159; y1 = 7'd0; colour = 3'd4; start = 1'b1;
    push(0, 0, 0, 0, 4);
    for (int i = 0; i <= 20; i++) push(1, 0, mx[i], my[i], 4);
    repeat (22) @(negedge CLOCK_50);
    reset = 1'b1;
    start = 1'b0;
    push(0, 0, 0, 0, 0);
    @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    run_line(3, 7, 40, 90, 6, 1);

    // Random lines, with model properties cross-checked each time.
    for (int t = 0; t < 25; t++) begin
      ax0 = $urandom_range(0, 255); ay0 = $urandom_range(0, 127);
      ax1 = $urandom_range(0, 255); ay1 = $urandom_range(0, 127);
      if (t % 2 == 0) begin
        ax0 = ax0 % 160; ax1 = ax1 % 160; ay0 = ay0 % 120; ay1 = ay1 % 120;
      end
      build(ax0, ay0, ax1, ay1);
      adx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
      ady = (ay1 > ay0) ? ay1 - ay0 : ay0 - ay1;
      mxd = (adx > ady) ? adx : ady;
      chk("model_count", mx.size(), mxd + 1);
      bad_unit = 0;
      for (int i = 1; i < mx.size(); i++) begin
        if ((mx[i] - mx[i-1]) * (mx[i] - mx[i-1]) > 1) bad_unit++;
        if ((my[i] - my[i-1]) * (my[i] - my[i-1]) > 1) bad_unit++;
        if (mx[i] == mx[i-1] && my[i] == my[i-1]) bad_unit++;
      end
      chk("model_step", bad_unit, 0);
      run_line(ax0, ay0, ax1, ay1, $urandom_range(0, 7), $urandom_range(1, 3));
    end

    repeat (3) @(negedge CLOCK_50);
    if (exp_q.size() != 0) chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
